lsq: RTL and testbench
======================

Name: lsq

Overview:
Load/store queue that receives committed memory operations from the execute stage and issues them to the data memory port in order. Loads get their returned data extracted and extended, then written back to the register file. The block sits between the execute stage's `lsq_*` outputs and the data bus. It also provides a regfile write port that is separate from the execute-stage write-back.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- XLEN, `RV_XLEN (32), data/address width.

Ports:
- clk_i  in  1  clock.
- resetb_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  global clock enable; all state advances only when high.
- lq_wr_i  in  1  push load entry.
- sq_wr_i  in  1  push store entry.
- funct3_i  in  3  RV32I load/store funct3.
- regd_addr_i  in  5  load destination register.
- regs2_data_i  in  XLEN  store data (unaligned, low bits).
- addr_i  in  XLEN  effective byte address.
- full_o  out  1  queue full; execute stage stalls on it.
- empty_o  out  1  queue empty and no request outstanding.
- dmem_req_o  out  1  bus request.
- dmem_wr_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  XLEN  word address ({addr[XLEN-1:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_ack_i  in  1  bus accept/complete; load rdata valid same cycle.
- dmem_rdata_i  in  XLEN  load read data.
- regd_wr_o  out  1  load write-back strobe.
- regd_addr_o  out  5  write-back register.
- regd_data_o  out  XLEN  write-back data.

Behaviour:
- Reset values: all outputs 0 except empty_o = 1. Pointers, count and FSM are cleared. Reset mid-transaction drops dmem_req_o immediately (async) and discards all entries.
- Queue storage:
  - Circular FIFO with entry {is_store, funct3, regd_addr, addr, data}.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - A push is sampled at a clk_en_i edge when lq_wr_i|sq_wr_i.
  - Push and pop in the same cycle leave count unchanged.
- Boundary conditions:
  - full_o = (count == DEPTH), driven from registers.
  - A push while full is ignored and flagged by a simulation assertion.
  - lq_wr_i & sq_wr_i together is illegal (assertion); the entry is treated as a store.
- FSM, single outstanding request:
  - IDLE: when count != 0 at a clk_en_i edge, register head-entry outputs and set dmem_req_o; go to REQ.
  - REQ: hold dmem_* stable until dmem_ack_i is sampled high at a clk_en_i edge. On that edge, pop the head.
    - If the remaining count != 0, stay in REQ and load the next head, keeping dmem_req_o high (back-to-back).
    - Otherwise clear dmem_req_o and go to IDLE.
- Latency: push at edge E0 → dmem_req_o high after E1 → ack sampled at E2 → regd_wr_o high for the one cycle after E2.
- Store alignment by funct3, with a = addr[1:0]:
  - SB: data = {4{b}}, be = 1<<a.
  - SH: data = {2{h}}, be = 0011<<a.
  - SW: data = word, be = 1111.
  - Loads drive be per the same rule and dmem_wdata_o = 0.
- Load extraction: shift dmem_rdata_i right by 8*a, then extend per funct3.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Extraction is registered into regd_data_o on the ack edge.
- Store acks produce no write-back. Loads to x0 still write back (the regfile ignores x0).
- Misalignment is excluded upstream; the block does not check it.
- empty_o = (count == 0) & FSM in IDLE & ~regd_wr_o.
- clk_en_i low: all registers hold; dmem_ack_i is not sampled. The memory must hold ack until a clk_en_i edge.

Decomposition:
- Add to riscv_defs.v:
  - LSQ funct3 encodings (LSQ_LB … LSQ_LHU).
  - LSQ_IDLE/LSQ_REQ state encodings.
  - LSQ entry field widths.
- Natural sub-module: lsq_fifo (storage, pointers, count, full/empty).
- Alignment and extension stay in lsq.

Test Plan:
- Single LW: push addr 0x100, regd 5; ack with rdata 0xDEADBEEF → dmem_addr_o = 0x100, be = 1111, regd_wr_o one cycle after ack, regd 5 = 0xDEADBEEF.
- LB/LBU at addr 0x103, rdata 0x80112233 → LB writes 0xFFFFFF80, LBU writes 0x00000080. LH at 0x102 → 0xFFFF8011.
- SB at 0x201 with data 0x000000A5 → dmem_wr_o = 1, be = 0010, wdata = 0xA5A5A5A5, no regd_wr_o.
- Fill 4 entries with ack held low → full_o = 1 after the 4th push. A 5th push is ignored (assertion fires). After one ack, full_o = 0 and the next head issues back-to-back with req held high.
- Simultaneous push and pop at count = 2 → count stays 2. Order across 8 mixed ops with random ack delays is preserved (scoreboard).
- Assert resetb_i while in REQ with 3 entries → dmem_req_o = 0 immediately, empty_o = 1, full_o = 0. After release, a new push issues normally.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared encodings, field widths and byte-enable helper for the load/store queue.
package lsq_pkg;
    localparam int RV_XLEN  = 32;
    localparam int LSQ_F3_W = 3;
    localparam int LSQ_RD_W = 5;

    localparam logic [2:0] LSQ_LB  = 3'b000;
    localparam logic [2:0] LSQ_LH  = 3'b001;
    localparam logic [2:0] LSQ_LW  = 3'b010;
    localparam logic [2:0] LSQ_LBU = 3'b100;
    localparam logic [2:0] LSQ_LHU = 3'b101;

    localparam logic [0:0] LSQ_IDLE = 1'b0;
    localparam logic [0:0] LSQ_REQ  = 1'b1;

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic [3:0] lsq_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lsq_be = 4'b0001 << off;
            2'b01:   lsq_be = 4'b0011 << off;
            default: lsq_be = 4'b1111;
        endcase
    endfunction
endpackage

// File: rtl/lsq_fifo.sv
// Circular entry store for the LSQ; exposes the head and the entry behind it
// so back-to-back issue can load the next request on the pop edge.
module lsq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   resetb_i,
    input  logic                   clk_en_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           head,
    output logic [W-1:0]           head_nxt,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = clk_en_i & push & ~full;
    assign do_pop   = clk_en_i & pop & ~empty;
    assign head     = mem[rd_ptr];
    assign head_nxt = mem[rd_ptr + PW'(1)];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/lsq.sv
// Load/store queue: issues committed memory ops in order, one outstanding
// request at a time, and writes aligned/extended load data back to the regfile.
module lsq
    import lsq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = RV_XLEN
) (
    input  logic                clk_i,
    input  logic                resetb_i,
    input  logic                clk_en_i,
    input  logic                lq_wr_i,
    input  logic                sq_wr_i,
    input  logic [2:0]          funct3_i,
    input  logic [4:0]          regd_addr_i,
    input  logic [XLEN-1:0]     regs2_data_i,
    input  logic [XLEN-1:0]     addr_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                dmem_req_o,
    output logic                dmem_wr_o,
    output logic [XLEN-1:0]     dmem_addr_o,
    output logic [3:0]          dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_ack_i,
    input  logic [XLEN-1:0]     dmem_rdata_i,
    output logic                regd_wr_o,
    output logic [4:0]          regd_addr_o,
    output logic [XLEN-1:0]     regd_data_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 1 + LSQ_F3_W + LSQ_RD_W + 2 * XLEN;

    logic [EW-1:0]       head;
    logic [EW-1:0]       head_nxt;
    logic [EW-1:0]       nxt;
    logic [CW-1:0]       count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                ack_fire;
    logic [0:0]          state;

    logic                n_store;
    logic [LSQ_F3_W-1:0] n_f3;
    logic [LSQ_RD_W-1:0] n_rd;
    logic [XLEN-1:0]     n_addr;
    logic [XLEN-1:0]     n_data;
    logic [XLEN-1:0]     n_wdata;

    logic [LSQ_F3_W-1:0] cur_f3;
    logic [1:0]          cur_off;
    logic [LSQ_RD_W-1:0] cur_rd;
    logic [XLEN-1:0]     ld_sh;
    logic [XLEN-1:0]     ld_data;

    // A simultaneous load+store push is stored as a store.
    assign push     = lq_wr_i | sq_wr_i;
    assign ack_fire = clk_en_i & (state == LSQ_REQ) & dmem_ack_i;

    lsq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetb_i (resetb_i),
        .clk_en_i (clk_en_i),
        .push     (push),
        .pop      (ack_fire),
        .wdata    ({sq_wr_i, funct3_i, regd_addr_i, addr_i, regs2_data_i}),
        .head     (head),
        .head_nxt (head_nxt),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign full_o  = fifo_full;
    assign empty_o = fifo_empty & (state == LSQ_IDLE) & ~regd_wr_o;

    // While a request is outstanding its entry is still the head, so the
    // next request to load is the one behind it.
    assign nxt = (state == LSQ_REQ) ? head_nxt : head;
    assign {n_store, n_f3, n_rd, n_addr, n_data} = nxt;

    always_comb begin
        n_wdata = '0;
        if (n_store) begin
            case (n_f3[1:0])
                2'b00:   n_wdata = {(XLEN/8){n_data[7:0]}};
                2'b01:   n_wdata = {(XLEN/16){n_data[15:0]}};
                default: n_wdata = n_data;
            endcase
        end
    end

    assign ld_sh = dmem_rdata_i >> {cur_off, 3'b000};

    always_comb begin
        case (cur_f3)
            LSQ_LB:  ld_data = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
            LSQ_LH:  ld_data = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
            LSQ_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
            LSQ_LHU: ld_data = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
            default: ld_data = ld_sh;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state        <= LSQ_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_wr_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            cur_f3       <= '0;
            cur_off      <= '0;
            cur_rd       <= '0;
            regd_wr_o    <= 1'b0;
            regd_addr_o  <= '0;
            regd_data_o  <= '0;
        end else if (clk_en_i) begin
            regd_wr_o <= 1'b0;
            if (ack_fire && !dmem_wr_o) begin
                regd_wr_o   <= 1'b1;
                regd_addr_o <= cur_rd;
                regd_data_o <= ld_data;
            end
            if ((state == LSQ_IDLE && !fifo_empty) || (ack_fire && count > CW'(1))) begin
                state        <= LSQ_REQ;
                dmem_req_o   <= 1'b1;
                dmem_wr_o    <= n_store;
                dmem_addr_o  <= {n_addr[XLEN-1:2], 2'b00};
                dmem_be_o    <= lsq_be(n_f3, n_addr[1:0]);
                dmem_wdata_o <= n_wdata;
                cur_f3       <= n_f3;
                cur_off      <= n_addr[1:0];
                cur_rd       <= n_rd;
            end else if (ack_fire) begin
                state      <= LSQ_IDLE;
                dmem_req_o <= 1'b0;
            end
        end
    end

    a_no_dual_push: assert property (@(posedge clk_i) disable iff (!resetb_i)
        clk_en_i |-> !(lq_wr_i && sq_wr_i))
        else $error("lsq: load and store pushed in the same cycle");

    // Dropping a push is recoverable, so this only warns.
    a_push_full: assert property (@(posedge clk_i) disable iff (!resetb_i)
        (clk_en_i && push) |-> !fifo_full)
        else $warning("lsq: push while full dropped");
endmodule

// File: tb/tb_lsq.sv
// Self-checking bench for lsq: directed scenarios plus a randomized ordering
// run scored against a queue-based reference model.
module tb_lsq;
    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        lq_wr_i = 1'b0;
    logic        sq_wr_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  regd_addr_i = '0;
    logic [31:0] regs2_data_i = '0;
    logic [31:0] addr_i = '0;
    logic        full_o;
    logic        empty_o;
    logic        dmem_req_o;
    logic        dmem_wr_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        regd_wr_o;
    logic [4:0]  regd_addr_o;
    logic [31:0] regd_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    lsq #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .lq_wr_i(lq_wr_i), .sq_wr_i(sq_wr_i), .funct3_i(funct3_i),
        .regd_addr_i(regd_addr_i), .regs2_data_i(regs2_data_i), .addr_i(addr_i),
        .full_o(full_o), .empty_o(empty_o), .dmem_req_o(dmem_req_o), .dmem_wr_o(dmem_wr_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o), .regd_data_o(regd_data_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned nbytes;
        int unsigned mask;
        nbytes = 1 << f3[1:0];
        mask   = (1 << nbytes) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input bit st, input logic [2:0] f3, input logic [31:0] d);
        if (!st) return 32'h0;
        case (f3[1:0])
            2'b00:   return (d & 32'hFF) * 32'h01010101;
            2'b01:   return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = r >> (8 * (a % 4));
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (f3)
            3'd0:    return b - ((b & 32'h80) << 1);
            3'd1:    return h - ((h & 32'h8000) << 1);
            3'd4:    return b;
            3'd5:    return h;
            default: return v;
        endcase
    endfunction

    function automatic op_t mk(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.st = st; o.f3 = f3; o.rd = rd; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int sz;
        o.st = bit'($urandom_range(1, 0));
        sz   = $urandom_range(2, 0);
        if (o.st || sz == 2) o.f3 = 3'(sz);
        else                 o.f3 = 3'(sz + ($urandom_range(1, 0) * 4));
        o.rd   = 5'($urandom_range(31, 0));
        o.addr = $urandom & ~((32'h1 << sz) - 32'h1);
        o.data = $urandom;
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_op(input op_t o);
        lq_wr_i = !o.st; sq_wr_i = o.st; funct3_i = o.f3;
        regd_addr_i = o.rd; addr_i = o.addr; regs2_data_i = o.data;
    endtask

    task automatic push_op(input op_t o);
        drive_op(o);
        tick();
        lq_wr_i = 1'b0; sq_wr_i = 1'b0;
    endtask

    task automatic ack_once(input logic [31:0] rdata);
        dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        tick();
        dmem_ack_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetb_i = 1'b0;
        tick(); tick();
        checks++;
        if (dmem_req_o !== 1'b0 || dmem_wr_o !== 1'b0 || dmem_addr_o !== 32'h0 ||
            dmem_be_o !== 4'h0 || dmem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_dmem: req=%b wr=%b addr=%h be=%b wd=%h, want all zero",
                     dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
        end
        checks++;
        if (regd_wr_o !== 1'b0 || regd_addr_o !== 5'h0 || regd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_regd: wr=%b addr=%h data=%h, want zero", regd_wr_o, regd_addr_o, regd_data_o);
        end
        checks++;
        if (full_o !== 1'b0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: full=%b empty=%b, want full=0 empty=1", full_o, empty_o);
        end
        resetb_i = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        push_op(mk(1'b0, 3'b010, 5'd5, 32'h100, 32'h0));
        checks++;
        if (dmem_req_o !== 1'b0 || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_e0: req=%b empty=%b, want req=0 empty=0", dmem_req_o, empty_o);
        end
        tick();
        checks++;
        if (dmem_req_o !== 1'b1 || dmem_wr_o !== 1'b0 || dmem_addr_o !== 32'h100 ||
            dmem_be_o !== 4'b1111 || dmem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL lw_req: req=%b wr=%b addr=%h be=%b wd=%h, want 1 0 00000100 1111 0",
                     dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
        end
        checks++;
        if (regd_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_early_wb: regd_wr=%b, want 0", regd_wr_o);
        end
        ack_once(32'hDEADBEEF);
        checks++;
        if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'd5 || regd_data_o !== 32'hDEADBEEF || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb: wr=%b rd=%0d data=%h req=%b, want 1 5 deadbeef 0",
                     regd_wr_o, regd_addr_o, regd_data_o, dmem_req_o);
        end
        tick();
        checks++;
        if (regd_wr_o !== 1'b0 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL lw_after: regd_wr=%b empty=%b, want 0 1", regd_wr_o, empty_o);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] adrs [3] = '{32'h103, 32'h103, 32'h102};
        logic [3:0]  bes  [3] = '{4'b1000, 4'b1000, 4'b1100};
        logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011};
        for (int i = 0; i < 3; i++) begin
            push_op(mk(1'b0, f3s[i], 5'(10 + i), adrs[i], 32'h0));
            tick();
            checks++;
            if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h100 || dmem_be_o !== bes[i]) begin
                errors++;
                $display("FAIL ext_req%0d: req=%b addr=%h be=%b, want 1 00000100 %b",
                         i, dmem_req_o, dmem_addr_o, dmem_be_o, bes[i]);
            end
            ack_once(32'h80112233);
            checks++;
            if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'(10 + i) || regd_data_o !== exps[i]) begin
                errors++;
                $display("FAIL ext_wb%0d: wr=%b rd=%0d data=%h, want 1 %0d %h",
                         i, regd_wr_o, regd_addr_o, regd_data_o, 10 + i, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_sb();
        push_op(mk(1'b1, 3'b000, 5'd0, 32'h201, 32'h000000A5));
        tick();
        checks++;
        if (dmem_req_o !== 1'b1 || dmem_wr_o !== 1'b1 || dmem_addr_o !== 32'h200 ||
            dmem_be_o !== 4'b0010 || dmem_wdata_o !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL sb_req: req=%b wr=%b addr=%h be=%b wd=%h, want 1 1 00000200 0010 a5a5a5a5",
                     dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
        end
        ack_once(32'hFFFFFFFF);
        checks++;
        if (regd_wr_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_nowb: regd_wr=%b req=%b, want 0 0", regd_wr_o, dmem_req_o);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            push_op(mk(1'b0, 3'b010, 5'(i), 32'h300 + 32'(4 * (i - 1)), 32'h0));
            checks++;
            if (full_o !== (i == 4)) begin
                errors++;
                $display("FAIL full_fill%0d: full=%b, want %b", i, full_o, i == 4);
            end
        end
        push_op(mk(1'b0, 3'b010, 5'd9, 32'h3F0, 32'h0));
        checks++;
        if (full_o !== 1'b1) begin
            errors++;
            $display("FAIL full_5th: full=%b, want 1", full_o);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h300 + 32'(4 * (i - 1))) begin
                errors++;
                $display("FAIL full_issue%0d: req=%b addr=%h, want 1 %h",
                         i, dmem_req_o, dmem_addr_o, 32'h300 + 32'(4 * (i - 1)));
            end
            ack_once(32'hC0DE0000 + 32'(i));
            checks++;
            if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'(i) || regd_data_o !== 32'hC0DE0000 + 32'(i) ||
                full_o !== 1'b0 || dmem_req_o !== (i < 4)) begin
                errors++;
                $display("FAIL full_drain%0d: wr=%b rd=%0d data=%h full=%b req=%b, want 1 %0d %h 0 %b",
                         i, regd_wr_o, regd_addr_o, regd_data_o, full_o, dmem_req_o,
                         i, 32'hC0DE0000 + 32'(i), i < 4);
            end
        end
        tick(); tick();
        checks++;
        if (empty_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL full_dropped: empty=%b req=%b, want 1 0", empty_o, dmem_req_o);
        end
    endtask

    task automatic test_push_pop();
        push_op(mk(1'b0, 3'b010, 5'd1, 32'h400, 32'h0));
        push_op(mk(1'b0, 3'b010, 5'd2, 32'h404, 32'h0));
        // push C while A is acked: occupancy stays at two
        drive_op(mk(1'b0, 3'b010, 5'd3, 32'h408, 32'h0));
        ack_once(32'h11);
        lq_wr_i = 1'b0;
        checks++;
        if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'd1 || dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h404) begin
            errors++;
            $display("FAIL pp_pop: wr=%b rd=%0d req=%b addr=%h, want 1 1 1 00000404",
                     regd_wr_o, regd_addr_o, dmem_req_o, dmem_addr_o);
        end
        push_op(mk(1'b0, 3'b010, 5'd4, 32'h40C, 32'h0));
        checks++;
        if (full_o !== 1'b0) begin
            errors++;
            $display("FAIL pp_cnt3: full=%b, want 0", full_o);
        end
        push_op(mk(1'b0, 3'b010, 5'd5, 32'h410, 32'h0));
        checks++;
        if (full_o !== 1'b1) begin
            errors++;
            $display("FAIL pp_cnt4: full=%b, want 1", full_o);
        end
        for (int i = 2; i <= 5; i++) begin
            ack_once(32'(i));
            checks++;
            if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'(i)) begin
                errors++;
                $display("FAIL pp_order%0d: wr=%b rd=%0d, want 1 %0d", i, regd_wr_o, regd_addr_o, i);
            end
        end
        tick();
        checks++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL pp_empty: empty=%b, want 1", empty_o);
        end
    endtask

    task automatic test_clk_en();
        push_op(mk(1'b0, 3'b010, 5'd7, 32'h40, 32'h0));
        tick();
        clk_en_i = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
        drive_op(mk(1'b0, 3'b010, 5'd8, 32'h44, 32'h0));
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dmem_req_o !== 1'b1 || regd_wr_o !== 1'b0) begin
                errors++;
                $display("FAIL cen_hold%0d: req=%b regd_wr=%b, want 1 0", i, dmem_req_o, regd_wr_o);
            end
        end
        lq_wr_i = 1'b0;
        clk_en_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        checks++;
        if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'd7 || regd_data_o !== 32'h12345678 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL cen_ack: wr=%b rd=%0d data=%h req=%b, want 1 7 12345678 0",
                     regd_wr_o, regd_addr_o, regd_data_o, dmem_req_o);
        end
        tick();
        checks++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL cen_empty: empty=%b, want 1", empty_o);
        end
    endtask

    task automatic test_random_order();
        op_t         q[$];
        op_t         o;
        logic [31:0] rv;
        logic [31:0] pend_data;
        logic [4:0]  pend_rd;
        bit          pend_ld;
        bit          acked;
        int          pushed = 0;
        int          done = 0;
        int          cyc = 0;
        while (done < 8 && cyc < 400) begin
            acked = 1'b0;
            if (pushed < 8 && !full_o && $urandom_range(1, 0) == 1) begin
                o = rand_op();
                drive_op(o);
                q.push_back(o);
                pushed++;
            end
            if (dmem_req_o && q.size() > 0 && $urandom_range(2, 0) == 0) begin
                checks++;
                if (dmem_wr_o !== q[0].st || dmem_addr_o !== (q[0].addr & ~32'h3) ||
                    dmem_be_o !== exp_be(q[0].f3, q[0].addr) ||
                    dmem_wdata_o !== exp_wdata(q[0].st, q[0].f3, q[0].data)) begin
                    errors++;
                    $display("FAIL rand_req%0d: wr=%b addr=%h be=%b wd=%h, want %b %h %b %h",
                             done, dmem_wr_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, q[0].st,
                             q[0].addr & ~32'h3, exp_be(q[0].f3, q[0].addr),
                             exp_wdata(q[0].st, q[0].f3, q[0].data));
                end
                rv = $urandom;
                dmem_ack_i = 1'b1; dmem_rdata_i = rv;
                pend_ld   = !q[0].st;
                pend_rd   = q[0].rd;
                pend_data = exp_load(q[0].f3, q[0].addr, rv);
                void'(q.pop_front());
                done++;
                acked = 1'b1;
            end
            tick();
            lq_wr_i = 1'b0; sq_wr_i = 1'b0; dmem_ack_i = 1'b0;
            checks++;
            if (regd_wr_o !== (acked && pend_ld)) begin
                errors++;
                $display("FAIL rand_wbstrobe c%0d: regd_wr=%b, want %b", cyc, regd_wr_o, acked && pend_ld);
            end
            if (acked && pend_ld) begin
                checks++;
                if (regd_addr_o !== pend_rd || regd_data_o !== pend_data) begin
                    errors++;
                    $display("FAIL rand_wb c%0d: rd=%0d data=%h, want %0d %h",
                             cyc, regd_addr_o, regd_data_o, pend_rd, pend_data);
                end
            end
            cyc++;
        end
        checks++;
        if (done != 8) begin
            errors++;
            $display("FAIL rand_timeout: completed %0d of 8 ops", done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push_op(mk(1'b0, 3'b010, 5'(20 + i), 32'h500 + 32'(4 * i), 32'h0));
        checks++;
        if (dmem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: req=%b, want 1", dmem_req_o);
        end
        #2;
        resetb_i = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: req=%b empty=%b full=%b, want 0 1 0", dmem_req_o, empty_o, full_o);
        end
        tick(); tick();
        resetb_i = 1'b1;
        tick();
        push_op(mk(1'b0, 3'b010, 5'd3, 32'h80, 32'h0));
        tick();
        checks++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h80) begin
            errors++;
            $display("FAIL arst_reissue: req=%b addr=%h, want 1 00000080", dmem_req_o, dmem_addr_o);
        end
        ack_once(32'hA1B2C3D4);
        checks++;
        if (regd_wr_o !== 1'b1 || regd_addr_o !== 5'd3 || regd_data_o !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL arst_wb: wr=%b rd=%0d data=%h, want 1 3 a1b2c3d4", regd_wr_o, regd_addr_o, regd_data_o);
        end
        tick();
        checks++;
        if (empty_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_drained: empty=%b req=%b, want 1 0", empty_o, dmem_req_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_lw();
        test_load_extend();
        test_sb();
        test_full();
        test_push_pop();
        test_clk_en();
        test_random_order();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
